// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
// Instruction fetch front end. It drives the program counter update interface,
// sends fetch requests to instruction memory over a valid/ready channel, and
// buffers the returned instructions with their PC tags for decode. It also
// handles branch/jump redirects by flushing the buffer and discarding data
// that is still in flight.
//
// Ports:
//   Clk, Reset             clock; synchronous active-low reset
//   PCResult / PCNext      current PC in; next PC out
//   PCWrite                PC load enable
//   IMemReq*               fetch request: Valid/Addr out, Ready in
//   IMemResp*              fetch response: Valid/Data in (variable latency)
//   Instr* / InstrReady    buffer head to decode: Valid/Instr/PC out, Ready in
//   Redirect*              taken branch/jump and its target PC
module fetch_pc_ctrl #(
  parameter int BUF_DEPTH = 2,
  parameter int PC_STEP   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  output logic [31:0] PCNext,
  output logic        PCWrite,
  output logic        IMemReqValid,
  output logic [31:0] IMemReqAddr,
  input  logic        IMemReqReady,
  input  logic        IMemRespValid,
  input  logic [31:0] IMemRespData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   count_r, count_s;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [31:0]     tag_r;
  logic [31:0]     buf_instr_r [BUF_DEPTH];
  logic [31:0]     buf_pc_r    [BUF_DEPTH];

  logic            head_valid_s;
  logic            req_valid_s;
  logic            handshake_s;
  logic            push_s;
  logic            pop_s;

  // Handshake, push and pop qualifiers; a redirect cancels all of them.
  always_comb begin
    head_valid_s = (count_r != {CW{1'b0}});
    req_valid_s  = Reset && (state_r == REQ) && !Redirect;
    handshake_s  = req_valid_s && IMemReqReady;
    push_s       = Reset && (state_r == WAIT) && IMemRespValid && !Redirect;
    pop_s        = Reset && head_valid_s && InstrReady && !Redirect;
  end

  // Occupancy after this cycle; a redirect empties the buffer.
  always_comb begin
    count_s = count_r;
    if (Redirect) begin
      count_s = {CW{1'b0}};
    end else begin
      count_s = count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Next-state logic. The issue decision uses the post-push/pop occupancy so a
  // new request is only made when its response is guaranteed a free slot.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Redirect) begin
          state_s = REQ;
        end else if (count_r < CW'(BUF_DEPTH)) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (Redirect) begin
          state_s = REQ;
        end else if (handshake_s) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (Redirect) begin
          // A response that arrives with the redirect is simply dropped here;
          // without one, the stale response is still owed and must be eaten.
          state_s = IMemRespValid ? REQ : DROP;
        end else if (IMemRespValid) begin
          state_s = (count_s < CW'(BUF_DEPTH)) ? REQ : IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (Redirect) begin
          state_s = DROP;
        end else if (IMemRespValid) begin
          state_s = REQ;
        end else begin
          state_s = DROP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // PC update and request/decode outputs; everything is forced quiet in reset.
  always_comb begin
    PCWrite      = 1'b0;
    PCNext       = PCResult;
    IMemReqValid = req_valid_s;
    IMemReqAddr  = PCResult;
    InstrValid   = 1'b0;
    Instr        = 32'd0;
    InstrPC      = 32'd0;
    if (!Reset) begin
      PCNext = 32'd0;
    end else begin
      if (Redirect) begin
        PCWrite = 1'b1;
        PCNext  = RedirectTarget;
      end else if (handshake_s) begin
        PCWrite = 1'b1;
        PCNext  = PCResult + 32'(PC_STEP);
      end else begin
        PCWrite = 1'b0;
        PCNext  = PCResult;
      end
      InstrValid = head_valid_s;
      Instr      = buf_instr_r[rd_ptr_r];
      InstrPC    = buf_pc_r[rd_ptr_r];
    end
  end

  // State, tag and FIFO storage registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r  <= IDLE;
      count_r  <= {CW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      tag_r    <= 32'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_r[i] <= 32'd0;
        buf_pc_r[i]    <= 32'd0;
      end
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      if (handshake_s) begin
        tag_r <= PCResult;
      end
      if (Redirect) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) begin
          buf_instr_r[wr_ptr_r] <= IMemRespData;
          buf_pc_r[wr_ptr_r]    <= tag_r;
          wr_ptr_r              <= wr_ptr_r + PW'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCResult;
  logic [31:0] PCNext;
  logic        PCWrite;
  logic        IMemReqValid;
  logic [31:0] IMemReqAddr;
  logic        IMemReqReady;
  logic        IMemRespValid;
  logic [31:0] IMemRespData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrReady;
  logic        Redirect;
  logic [31:0] RedirectTarget;

  int   tests_run;
  int   tests_failed;
  logic auto_resp;

  fetch_pc_ctrl #(.BUF_DEPTH(2), .PC_STEP(4)) dut (
    .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .PCNext(PCNext),
    .PCWrite(PCWrite), .IMemReqValid(IMemReqValid), .IMemReqAddr(IMemReqAddr),
    .IMemReqReady(IMemReqReady), .IMemRespValid(IMemRespValid),
    .IMemRespData(IMemRespData), .InstrValid(InstrValid), .Instr(Instr),
    .InstrPC(InstrPC), .InstrReady(InstrReady), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: PC register model, one-cycle memory model, redirect is a pulse.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    logic        pw;
    logic [31:0] pn;
    hs = IMemReqValid && IMemReqReady;
    a  = IMemReqAddr;
    pw = PCWrite;
    pn = PCNext;
    @(posedge Clk);
    #1;
    if (pw) PCResult = pn;
    Redirect = 1'b0;
    if (auto_resp && hs) begin
      IMemRespValid = 1'b1;
      IMemRespData  = mem_word(a);
    end else begin
      IMemRespValid = 1'b0;
      IMemRespData  = 32'd0;
    end
    #1;
  endtask

  // Reset, then release; returns in the first REQ cycle.
  task automatic do_reset(input logic [31:0] pc);
    Reset    = 1'b0;
    Redirect = 1'b0;
    tick();
    tick();
    Reset    = 1'b1;
    PCResult = pc;
    settle();
    tick();
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    auto_resp      = 1'b1;
    Reset          = 1'b0;
    PCResult       = 32'd0;
    IMemReqReady   = 1'b1;
    IMemRespValid  = 1'b0;
    IMemRespData   = 32'd0;
    InstrReady     = 1'b1;
    Redirect       = 1'b0;
    RedirectTarget = 32'd0;
    settle();

    // Reset and first fetch; a response and redirect during reset are ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      IMemRespValid  = 1'b1;
      IMemRespData   = 32'h0000_0BAD;
      Redirect       = 1'b1;
      RedirectTarget = 32'h0000_0F00;
      settle();
      check("rst_pcwrite", 32'(PCWrite), 32'd0);
      check("rst_pcnext", PCNext, 32'd0);
      check("rst_reqvalid", 32'(IMemReqValid), 32'd0);
      check("rst_instrvalid", 32'(InstrValid), 32'd0);
      check("rst_instr", Instr, 32'd0);
      check("rst_instrpc", InstrPC, 32'd0);
    end
    Reset         = 1'b1;
    Redirect      = 1'b0;
    IMemRespValid = 1'b0;
    IMemRespData  = 32'd0;
    settle();
    check("rel_idle_reqvalid", 32'(IMemReqValid), 32'd0);
    check("rel_idle_instrvalid", 32'(InstrValid), 32'd0);
    tick();
    check("first_reqvalid", 32'(IMemReqValid), 32'd1);
    check("first_addr", IMemReqAddr, 32'h0000_0000);
    check("first_pcwrite", 32'(PCWrite), 32'd1);
    check("first_pcnext", PCNext, 32'h0000_0004);
    tick();
    check("first_wait_pcwrite", 32'(PCWrite), 32'd0);
    check("first_wait_pcnext", PCNext, 32'h0000_0004);
    check("first_wait_reqvalid", 32'(IMemReqValid), 32'd0);
    tick();
    check("first_head_valid", 32'(InstrValid), 32'd1);
    check("first_head_pc", InstrPC, 32'h0000_0000);
    check("first_head_instr", Instr, mem_word(32'h0000_0000));

    // Sequential stream from 0x100
    do_reset(32'h0000_0100);
    InstrReady = 1'b1;
    settle();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h0000_0100 + 32'(4 * k);
      check("seq_addr", IMemReqAddr, exp_pc);
      check("seq_pcwrite", 32'(PCWrite), 32'd1);
      check("seq_pcnext", PCNext, exp_pc + 32'd4);
      if (k > 0) begin
        check("seq_head_valid", 32'(InstrValid), 32'd1);
        check("seq_head_pc", InstrPC, exp_pc - 32'd4);
        check("seq_head_instr", Instr, mem_word(exp_pc - 32'd4));
      end
      tick();
      check("seq_wait_pcwrite", 32'(PCWrite), 32'd0);
      check("seq_wait_instrvalid", 32'(InstrValid), 32'd0);
      tick();
    end

    // Backpressure with a two-entry buffer
    do_reset(32'h0000_0300);
    InstrReady = 1'b0;
    settle();
    check("bp_req0", 32'(IMemReqValid), 32'd1);
    check("bp_addr0", IMemReqAddr, 32'h0000_0300);
    tick();
    tick();
    check("bp_req1", 32'(IMemReqValid), 32'd1);
    check("bp_addr1", IMemReqAddr, 32'h0000_0304);
    check("bp_head_early", InstrPC, 32'h0000_0300);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_full_noreq", 32'(IMemReqValid), 32'd0);
      check("bp_full_valid", 32'(InstrValid), 32'd1);
      check("bp_hold_pc", InstrPC, 32'h0000_0300);
      check("bp_hold_instr", Instr, mem_word(32'h0000_0300));
      tick();
    end
    InstrReady = 1'b1;
    settle();
    check("bp_pop_noreq", 32'(IMemReqValid), 32'd0);
    tick();
    InstrReady = 1'b0;
    settle();
    check("bp_after_pop_noreq", 32'(IMemReqValid), 32'd0);
    check("bp_after_pop_head", InstrPC, 32'h0000_0304);
    tick();
    check("bp_reissue", 32'(IMemReqValid), 32'd1);
    check("bp_reissue_addr", IMemReqAddr, 32'h0000_0308);
    tick();
    check("bp_reissue_wait", 32'(IMemReqValid), 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      check("bp_refull_noreq", 32'(IMemReqValid), 32'd0);
      check("bp_refull_head", InstrPC, 32'h0000_0304);
      tick();
    end
    Redirect       = 1'b1;
    RedirectTarget = 32'h0000_0A00;
    settle();
    check("bp_redir_pcwrite", 32'(PCWrite), 32'd1);
    check("bp_redir_pcnext", PCNext, 32'h0000_0A00);
    tick();
    check("bp_flush_valid", 32'(InstrValid), 32'd0);
    check("bp_flush_req", 32'(IMemReqValid), 32'd1);
    check("bp_flush_addr", IMemReqAddr, 32'h0000_0A00);

    // Redirect while waiting; the late response is dropped
    auto_resp = 1'b0;
    do_reset(32'h0000_0200);
    InstrReady = 1'b1;
    settle();
    check("rw_pcnext", PCNext, 32'h0000_0204);
    tick();
    Redirect       = 1'b1;
    RedirectTarget = 32'h0000_0800;
    settle();
    check("rw_redir_pcwrite", 32'(PCWrite), 32'd1);
    check("rw_redir_pcnext", PCNext, 32'h0000_0800);
    check("rw_redir_noreq", 32'(IMemReqValid), 32'd0);
    tick();
    check("rw_drop_noreq", 32'(IMemReqValid), 32'd0);
    check("rw_drop_pcwrite", 32'(PCWrite), 32'd0);
    IMemRespValid = 1'b1;
    IMemRespData  = 32'h0000_1234;
    settle();
    tick();
    check("rw_dropped_valid", 32'(InstrValid), 32'd0);
    check("rw_next_req", 32'(IMemReqValid), 32'd1);
    check("rw_next_addr", IMemReqAddr, 32'h0000_0800);
    auto_resp = 1'b1;
    tick();
    tick();
    check("rw_head_valid", 32'(InstrValid), 32'd1);
    check("rw_head_pc", InstrPC, 32'h0000_0800);
    check("rw_head_instr", Instr, mem_word(32'h0000_0800));

    // Redirect and response in the same WAIT cycle
    auto_resp = 1'b0;
    do_reset(32'h0000_0400);
    InstrReady = 1'b0;
    settle();
    tick();
    Redirect       = 1'b1;
    RedirectTarget = 32'h0000_0900;
    IMemRespValid  = 1'b1;
    IMemRespData   = 32'h0000_5555;
    settle();
    check("sim_pcnext", PCNext, 32'h0000_0900);
    tick();
    check("sim_empty", 32'(InstrValid), 32'd0);
    check("sim_req", 32'(IMemReqValid), 32'd1);
    check("sim_addr", IMemReqAddr, 32'h0000_0900);

    // PC wrap-around
    auto_resp = 1'b1;
    do_reset(32'hFFFF_FFFC);
    InstrReady = 1'b0;
    settle();
    check("wrap_addr", IMemReqAddr, 32'hFFFF_FFFC);
    check("wrap_pcwrite", 32'(PCWrite), 32'd1);
    check("wrap_pcnext", PCNext, 32'h0000_0000);
    tick();
    check("wrap_pc_after", IMemReqAddr, 32'h0000_0000);
    tick();
    check("wrap_head_valid", 32'(InstrValid), 32'd1);
    check("wrap_head_pc", InstrPC, 32'hFFFF_FFFC);
    check("wrap_head_instr", Instr, mem_word(32'hFFFF_FFFC));

    // Reset mid-operation discards buffered data
    do_reset(32'h0000_0000);
    settle();
    check("midrst_valid", 32'(InstrValid), 32'd0);
    check("midrst_req", 32'(IMemReqValid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Drives the program counter's update interface: produces PCNext and PCWrite, and consumes PCResult.
- Fetches instructions from the instruction memory over a valid/ready request channel with a variable-latency response.
- Buffers fetched instructions with their PC tags for decode.
- Handles branch/jump redirects by flushing the buffer and discarding in-flight data.

Parameters:
- BUF_DEPTH, 2, number of instruction buffer entries; power of two, at least 2.
- PC_STEP, 4, byte increment applied to the PC per sequential fetch.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- PCResult  in  32  current PC from the program counter register.
- PCNext  out  32  next PC value presented to the program counter.
- PCWrite  out  1  program counter load enable.
- IMemReqValid  out  1  fetch request valid.
- IMemReqAddr  out  32  fetch address; always equals PCResult.
- IMemReqReady  in  1  memory accepts the request this cycle.
- IMemRespValid  in  1  response data valid.
- IMemRespData  in  32  fetched instruction word.
- InstrValid  out  1  buffer head is valid for decode.
- Instr  out  32  buffer head instruction.
- InstrPC  out  32  PC tag of the buffer head.
- InstrReady  in  1  decode consumes the head this cycle.
- Redirect  in  1  branch/jump taken; flush and retarget.
- RedirectTarget  in  32  new PC when Redirect is 1.

Behaviour:
- Reset: Reset=0 at a rising edge gives state=IDLE, buffer empty, tag register=0.
  - While in reset: PCWrite=0, PCNext=0, IMemReqValid=0, InstrValid=0, Instr=0, InstrPC=0.
  - Reset applied mid-operation discards all buffered and in-flight data. A response arriving during reset is ignored.
- States: IDLE, REQ, WAIT, DROP. At most one request is outstanding.
- IDLE:
  - Go to REQ when count < BUF_DEPTH.
  - Otherwise stay; leaving IDLE also requires Reset=1.
- REQ:
  - IMemReqValid=1 combinationally, unless Redirect=1.
  - On IMemReqValid & IMemReqReady:
    - PCWrite=1 and PCNext=PCResult+PC_STEP in the same cycle, so the PC advances at that edge.
    - Capture tag=PCResult.
    - Go to WAIT.
  - The PC add wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- WAIT:
  - On IMemRespValid, push {tag, IMemRespData} into the buffer.
  - Then go to REQ if (count after this cycle's push and pop) < BUF_DEPTH, else go to IDLE.
- DROP:
  - Wait for IMemRespValid, discard the data, then go to REQ.
- Issue rule: a request is issued only when a free slot exists, so a push never overflows the buffer.
- Buffer:
  - FIFO with registered head outputs; InstrValid = (count != 0).
  - Pop on InstrValid & InstrReady.
  - Push and pop in the same cycle leave count unchanged.
  - InstrReady while empty has no effect.
  - Instr and InstrPC are held stable while InstrValid=1 and InstrReady=0.
- Redirect (highest priority, any state except reset):
  - PCWrite=1 and PCNext=RedirectTarget that cycle.
  - IMemReqValid=0, so no handshake occurs.
  - Buffer is flushed (count=0 next cycle); a same-cycle pop or push is discarded.
  - Next state:
    - From WAIT without IMemRespValid in the same cycle: DROP.
    - From WAIT with IMemRespValid in the same cycle: the response is discarded, go to REQ.
    - From DROP: stay in DROP.
    - From IDLE or REQ: REQ.
- Outside REQ-handshake and Redirect cycles: PCWrite=0 and PCNext=PCResult.
- Latency: with IMemReqReady=1 and a one-cycle memory, a request accepted at edge t returns data at edge t+1. That instruction is visible on Instr in the cycle after edge t+1. Sequential throughput is one instruction per 2 cycles.

Test Plan:
- Reset and first fetch: hold Reset=0 for 3 cycles with PCResult=0, then release. Required: all outputs 0 during reset. IMemReqValid=1 with Addr=0x0 two cycles after release; PCWrite=1 and PCNext=0x4 in the handshake cycle.
- Sequential stream: PC starts at 0x100, IMemReqReady=1, response 1 cycle later, InstrReady=1. Required: InstrPC sequence 0x100, 0x104, 0x108 with matching data. PCWrite pulses once per fetch.
- Backpressure: BUF_DEPTH=2, InstrReady=0. Required: exactly 2 words buffered, then IMemReqValid stays 0. The head holds its value. Raising InstrReady for 1 cycle re-enables exactly one request.
- Redirect while waiting: request for 0x200 accepted, then Redirect=1 with RedirectTarget=0x800 before the response. Required: PCNext=0x800 and PCWrite=1 that cycle. The late response is dropped. The next request address is 0x800 and no 0x200-tagged instruction reaches decode.
- Simultaneous redirect and response: in WAIT, assert IMemRespValid and Redirect in the same cycle. Required: the buffer is empty next cycle, the response is not pushed, and the state goes directly to REQ.
- Wrap-around: PCResult=0xFFFFFFFC, handshake accepted. Required: PCNext=0x00000000 and InstrPC=0xFFFFFFFC.
